// File: rtl/dm_pipelined_if.sv
// Request/response channel between the pipelined MEM stage and dm_pipelined.
// The master drives requests and consumes responses; the slave is the memory.
interface dm_pipelined_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_pc;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_pc, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_pc, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dm_pipelined.sv
// Data memory for the pipelined MEM stage: sized, byte-enabled loads/stores with a
// registered 1-cycle response, access error flags and a word-by-word clear after reset.
module dm_pipelined #(
    parameter int unsigned DEPTH_WORDS = 3072,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter bit          LOG_EN      = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    dm_pipelined_if.slave bus
);
    localparam int unsigned      IDX_W        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(DEPTH_WORDS - 1);
    localparam logic [29:0]      DEPTH_W30    = 30'(DEPTH_WORDS);

    localparam logic [0:0]       ST_CLEAR     = 1'b0;
    localparam logic [0:0]       ST_RUN       = 1'b1;

    localparam logic [1:0]       SZ_WORD      = 2'b00;
    localparam logic [1:0]       SZ_HALF      = 2'b01;
    localparam logic [1:0]       SZ_BYTE      = 2'b10;

    localparam logic [1:0]       ERR_OK       = 2'b00;
    localparam logic [1:0]       ERR_MISALIGN = 2'b01;
    localparam logic [1:0]       ERR_RANGE    = 2'b10;
    localparam logic [1:0]       ERR_SIZE     = 2'b11;

    logic [31:0]      mem_r [0:DEPTH_WORDS-1];
    logic [0:0]       state_r;
    logic [IDX_W-1:0] clr_ptr_r;
    logic             rsp_valid_r;
    logic [31:0]      rsp_rdata_r;
    logic [1:0]       rsp_err_r;

    logic             req_ready_s;
    logic             accept_s;
    logic             store_s;
    logic             in_range_s;
    logic [31:0]      off_s;
    logic [1:0]       lane_s;
    logic [IDX_W-1:0] idx_s;
    logic [31:0]      rd_word_s;
    logic [31:0]      load_data_s;
    logic [31:0]      merged_s;
    logic [1:0]       err_s;

    function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] lane);
        logic [3:0] be;
        case (size)
            SZ_WORD: be = 4'hF;
            SZ_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
            SZ_BYTE: be = 4'b0001 << lane;
            default: be = 4'h0;
        endcase
        return be;
    endfunction

    // Store data arrives right-aligned; replicate it so every lane sees its bytes.
    function automatic logic [31:0] replicate_wdata(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] rep;
        case (size)
            SZ_HALF: rep = {2{wdata[15:0]}};
            SZ_BYTE: rep = {4{wdata[7:0]}};
            default: rep = wdata;
        endcase
        return rep;
    endfunction

    function automatic logic [31:0] merge_word(input logic [31:0] old_word, input logic [31:0] new_word,
                                               input logic [3:0] be);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
        end
        return res;
    endfunction

    function automatic logic [31:0] extract_load(input logic [31:0] word, input logic [1:0] size,
                                                 input logic [1:0] lane, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = word[{lane, 3'b000} +: 8];
        h = word[{lane[1], 4'b0000} +: 16];
        case (size)
            SZ_WORD: res = word;
            SZ_HALF: res = uns ? {16'h0000, h} : {{16{h[15]}}, h};
            SZ_BYTE: res = uns ? {24'h00_0000, b} : {{24{b[7]}}, b};
            default: res = 32'h0000_0000;
        endcase
        return res;
    endfunction

    assign off_s       = bus.req_addr - BASE_ADDR;
    assign lane_s      = off_s[1:0];
    assign idx_s       = off_s[IDX_W+1:2];
    assign in_range_s  = (off_s[31:2] < DEPTH_W30);
    assign req_ready_s = (state_r == ST_RUN) && (!rsp_valid_r || bus.rsp_ready);
    assign accept_s    = bus.req_valid && req_ready_s;
    assign store_s     = accept_s && bus.req_we && (err_s == ERR_OK);
    assign rd_word_s   = in_range_s ? mem_r[idx_s] : 32'h0000_0000;
    assign load_data_s = extract_load(rd_word_s, bus.req_size, lane_s, bus.req_unsigned);
    assign merged_s    = merge_word(rd_word_s, replicate_wdata(bus.req_size, bus.req_wdata),
                                    byte_enable(bus.req_size, lane_s));

    // Access classification; bad size outranks misalignment, which outranks range.
    always_comb begin
        err_s = ERR_OK;
        if (bus.req_size == ERR_SIZE) begin
            err_s = ERR_SIZE;
        end else if (((bus.req_size == SZ_WORD) && (bus.req_addr[1:0] != 2'b00)) ||
                     ((bus.req_size == SZ_HALF) && (bus.req_addr[0] != 1'b0))) begin
            err_s = ERR_MISALIGN;
        end else if (!in_range_s) begin
            err_s = ERR_RANGE;
        end else begin
            err_s = ERR_OK;
        end
    end

    // Clear sequencer: one zeroed word per cycle, then normal operation until the next reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_CLEAR;
            clr_ptr_r <= '0;
        end else if (state_r == ST_CLEAR) begin
            clr_ptr_r <= clr_ptr_r + 1'b1;
            if (clr_ptr_r == LAST_IDX) begin
                state_r <= ST_RUN;
            end
        end
    end

    // Storage array: clear writes during CLEAR, merged byte-enabled stores during RUN.
    always_ff @(posedge clk) begin
        if (state_r == ST_CLEAR) begin
            mem_r[clr_ptr_r] <= 32'h0000_0000;
        end else if (store_s) begin
            mem_r[idx_s] <= merged_s;
            if (LOG_EN) begin
                $display("@%h: *%h <= %h", bus.req_pc, {bus.req_addr[31:2], 2'b00}, merged_s);
            end
        end
    end

    // Response register: loads on accept, retires on rsp_ready, otherwise holds.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
            rsp_err_r   <= ERR_OK;
        end else if (accept_s) begin
            rsp_valid_r <= 1'b1;
            rsp_rdata_r <= ((err_s == ERR_OK) && !bus.req_we) ? load_data_s : 32'h0000_0000;
            rsp_err_r   <= err_s;
        end else if (bus.rsp_ready) begin
            rsp_valid_r <= 1'b0;
        end
    end

    assign bus.req_ready = req_ready_s;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_rdata = rsp_rdata_r;
    assign bus.rsp_err   = rsp_err_r;
endmodule

// File: tb/tb_dm_pipelined.sv
// Randomized scoreboard bench for dm_pipelined: a byte-array reference model predicts
// every response, and an independent monitor checks data, error, latency and hold.
module tb_dm_pipelined;
    localparam int          DEPTH = 3072;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  err;
        int          acc_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    dm_pipelined_if bus();

    dm_pipelined #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LOG_EN(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         checks   = 0;
    int         failures = 0;
    int         bp_mode  = 2;
    bit         mon_en   = 1'b0;
    exp_t       sbq[$];
    logic [7:0] model_b [0:4*DEPTH-1];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4*DEPTH; i++) model_b[i] = 8'h00;
    endtask

    // Reference behaviour: little-endian byte array, sizes in bytes, plain arithmetic.
    task automatic model_apply(input logic we, input logic [1:0] size, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               output logic [31:0] rd, output logic [1:0] er);
        logic [31:0] off;
        logic [31:0] val;
        logic [31:0] msk;
        int          n;
        off = addr - BASE;
        rd  = 32'h0;
        if (size == 2'd3)                                                  er = 2'd3;
        else if ((size == 2'd0 && addr % 4 != 0) || (size == 2'd1 && addr % 2 != 0)) er = 2'd1;
        else if ((off / 4) >= DEPTH)                                       er = 2'd2;
        else                                                               er = 2'd0;
        if (er == 2'd0) begin
            n = (size == 2'd0) ? 4 : (size == 2'd1) ? 2 : 1;
            if (we) begin
                for (int i = 0; i < n; i++) model_b[int'(off) + i] = 8'(wdata >> (8*i));
            end else begin
                val = 32'h0;
                for (int i = 0; i < n; i++) val = val | (32'(model_b[int'(off) + i]) << (8*i));
                if (!uns && n < 4) begin
                    msk = (32'h1 << (8*n)) - 32'h1;
                    if (val[8*n-1]) val = val | ~msk;
                end
                rd = val;
            end
        end
    endtask

    // Issue one request starting at a negedge; returns at the negedge after acceptance.
    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata);
        int          waitc;
        exp_t        e;
        logic [31:0] rd;
        logic [1:0]  er;
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        bus.req_pc       = 32'h0000_1000 + 32'(cyc) * 32'd4;
        waitc = 0;
        #1;
        while (!bus.req_ready && waitc < 200) begin
            @(negedge clk);
            #1;
            waitc++;
        end
        if (!bus.req_ready) begin
            chk("req_accept_timeout", {63'b0, bus.req_ready}, 64'd1);
        end else begin
            model_apply(we, size, uns, addr, wdata, rd, er);
            e.rdata   = rd;
            e.err     = er;
            e.acc_cyc = cyc + 1;
            sbq.push_back(e);
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    // Counts req_ready-low cycles from reset release (called right at release).
    task automatic wait_clear(input string name);
        int n;
        n = 0;
        while (!bus.req_ready && n < 5000) begin
            n++;
            @(negedge clk);
        end
        chk(name, 64'(n), 64'(DEPTH));
    endtask

    // Backpressure driver: random, forced low, or forced high.
    initial begin
        bus.rsp_ready = 1'b1;
        forever begin
            @(negedge clk);
            case (bp_mode)
                0:       bus.rsp_ready = ($urandom_range(0, 3) != 0);
                1:       bus.rsp_ready = 1'b0;
                default: bus.rsp_ready = 1'b1;
            endcase
        end
    end

    // Monitor: compares each new response with the scoreboard and checks hold stability.
    initial begin
        logic        held;
        logic [31:0] hd;
        logic [1:0]  he;
        exp_t        e;
        held = 1'b0;
        hd   = 32'h0;
        he   = 2'd0;
        forever begin
            @(negedge clk);
            #2;
            if (!mon_en) begin
                held = 1'b0;
            end else if (bus.rsp_valid) begin
                if (held) begin
                    chk("rsp_hold_rdata", 64'(bus.rsp_rdata), 64'(hd));
                    chk("rsp_hold_err", 64'(bus.rsp_err), 64'(he));
                end else if (sbq.size() == 0) begin
                    chk("rsp_unexpected", {63'b0, bus.rsp_valid}, 64'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(e.rdata));
                    chk("rsp_err", 64'(bus.rsp_err), 64'(e.err));
                    chk("rsp_latency", 64'(cyc), 64'(e.acc_cyc));
                end
                held = !bus.rsp_ready;
                hd   = bus.rsp_rdata;
                he   = bus.rsp_err;
            end else begin
                if (held) chk("rsp_dropped", {63'b0, bus.rsp_valid}, 64'd1);
                held = 1'b0;
            end
        end
    end

    initial begin
        logic [31:0] a;
        logic [1:0]  sz;
        int          r;
        int          waitc;

        reset            = 1'b0;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'd0;
        bus.req_unsigned = 1'b0;
        bus.req_pc       = 32'h0;
        bus.req_addr     = 32'h0;
        bus.req_wdata    = 32'h0;
        model_clear();

        // Reset state and full clear duration
        repeat (3) @(negedge clk);
        #1;
        chk("reset_rsp_valid", {63'b0, bus.rsp_valid}, 64'd0);
        chk("reset_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
        chk("reset_rsp_err", 64'(bus.rsp_err), 64'd0);
        chk("reset_req_ready", {63'b0, bus.req_ready}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        wait_clear("clear_cycles");
        mon_en = 1'b1;

        do_req(1'b0, 2'd0, 1'b0, BASE, 32'h0);
        do_req(1'b0, 2'd0, 1'b0, BASE + 32'(4*(DEPTH-1)), 32'h0);

        // Sized/extended loads from one word
        do_req(1'b1, 2'd0, 1'b0, BASE + 32'h10, 32'h8000_00FF);
        do_req(1'b0, 2'd2, 1'b0, BASE + 32'h13, 32'h0);
        do_req(1'b0, 2'd2, 1'b1, BASE + 32'h10, 32'h0);
        do_req(1'b0, 2'd1, 1'b0, BASE + 32'h12, 32'h0);

        // Partial stores merge into a zeroed word
        do_req(1'b1, 2'd2, 1'b0, BASE + 32'h21, 32'h0000_00AB);
        do_req(1'b1, 2'd1, 1'b0, BASE + 32'h22, 32'h0000_1234);
        do_req(1'b0, 2'd0, 1'b0, BASE + 32'h20, 32'h0);

        // Error cases leave memory untouched
        do_req(1'b0, 2'd0, 1'b0, BASE + 32'h6, 32'h0);
        do_req(1'b1, 2'd1, 1'b0, BASE + 32'h5, 32'hFFFF_FFFF);
        do_req(1'b0, 2'd0, 1'b0, BASE + 32'(4*DEPTH), 32'h0);
        do_req(1'b1, 2'd3, 1'b0, BASE + 32'h10, 32'hDEAD_BEEF);
        do_req(1'b0, 2'd0, 1'b0, BASE + 32'h4, 32'h0);
        do_req(1'b0, 2'd0, 1'b0, BASE + 32'h10, 32'h0);

        // Backpressure hold, then accept-and-retire on one edge
        bp_mode = 1;
        @(negedge clk);
        do_req(1'b0, 2'd2, 1'b0, BASE + 32'h10, 32'h0);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("hold_req_ready", {63'b0, bus.req_ready}, 64'd0);
            if (i == 3) bp_mode = 2;
            @(negedge clk);
        end
        fork
            do_req(1'b0, 2'd0, 1'b0, BASE + 32'h20, 32'h0);
            begin
                #1;
                chk("b2b_req_ready", {63'b0, bus.req_ready}, 64'd1);
                chk("b2b_rsp_valid", {63'b0, bus.rsp_valid}, 64'd1);
            end
        join

        // Randomized traffic with random backpressure
        bp_mode = 0;
        for (int k = 0; k < 300; k++) begin
            r = $urandom_range(0, 9);
            if (r <= 5)      a = BASE + 32'($urandom_range(0, 127));
            else if (r <= 7) a = BASE + 32'(4*DEPTH - 8) + 32'($urandom_range(0, 15));
            else if (r == 8) a = $urandom;
            else             a = BASE - 32'($urandom_range(1, 16));
            r  = $urandom_range(0, 9);
            sz = (r < 9) ? 2'(r % 3) : 2'd3;
            do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
            if ($urandom_range(0, 7) == 0) @(negedge clk);
        end

        bp_mode = 2;
        waitc = 0;
        while (sbq.size() != 0 && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        chk("drain_empty", 64'(sbq.size()), 64'd0);

        // Reset mid-clear restarts the full clear
        do_req(1'b1, 2'd0, 1'b0, BASE + 32'h40, 32'hDEAD_BEEF);
        repeat (3) @(negedge clk);
        mon_en = 1'b0;
        reset  = 1'b0;
        sbq.delete();
        model_clear();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (100) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        wait_clear("clear_restart_cycles");
        mon_en = 1'b1;

        // Reset while a response is pending drops it at once
        bp_mode = 1;
        @(negedge clk);
        do_req(1'b0, 2'd0, 1'b0, BASE + 32'h40, 32'h0);
        repeat (2) @(negedge clk);
        #1;
        chk("pending_rsp_valid", {63'b0, bus.rsp_valid}, 64'd1);
        mon_en = 1'b0;
        reset  = 1'b0;
        #1;
        chk("reset_drops_rsp", {63'b0, bus.rsp_valid}, 64'd0);
        sbq.delete();
        model_clear();
        bp_mode = 2;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        wait_clear("clear_after_rsp_reset");
        mon_en = 1'b1;
        do_req(1'b0, 2'd0, 1'b0, BASE + 32'h40, 32'h0);
        do_req(1'b0, 2'd0, 1'b0, BASE + 32'h10, 32'h0);

        waitc = 0;
        while (sbq.size() != 0 && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        chk("final_drain_empty", 64'(sbq.size()), 64'd0);
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
